// File: rtl/mips_lite_pkg.sv
// rtl/mips_lite_pkg.sv - shared constants and types for the MIPS-lite writeback path
package mips_lite_pkg;

  // alu_op value that marks a memory instruction (destination is rs)
  localparam logic [2:0] OP_MEM = 3'b111;

  localparam int REG_W     = 8;
  localparam int REG_IDX_W = 3;
  localparam int NUM_REGS  = 1 << REG_IDX_W;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } wb_state_t;

endpackage

// File: rtl/load_tracker.sv
// rtl/load_tracker.sv - tracks the single outstanding load, its timeout, busy bits and err
module load_tracker
  import mips_lite_pkg::*;
#(
  parameter int ADDR_W  = REG_IDX_W,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2:0]              alu_op,
  input  logic [ADDR_W-1:0]       rs,
  input  logic [ADDR_W-1:0]       rd,
  input  logic [ADDR_W-1:0]       dest,
  input  logic                    mem_rvalid,
  output wb_state_t               state,
  output logic                    done,
  output logic [2:0]              lat_alu_op,
  output logic [ADDR_W-1:0]       lat_rs,
  output logic [ADDR_W-1:0]       lat_rd,
  output logic [(1<<ADDR_W)-1:0]  busy,
  output logic                    err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt;

  // Load data arriving while a load is outstanding completes it; rvalid beats timeout
  assign done = (state == LOAD_WAIT) && mem_rvalid;

  // Load lifecycle: latch fields on entry, count idle wait cycles, finish on data or timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      lat_alu_op <= '0;
      lat_rs     <= '0;
      lat_rd     <= '0;
      busy       <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lat_alu_op <= alu_op;
            lat_rs     <= rs;
            lat_rd     <= rd;
            busy[dest] <= 1'b1;
            wait_cnt   <= '0;
            state      <= LOAD_WAIT;
          end
        end
        LOAD_WAIT: begin
          if (mem_rvalid) begin
            busy  <= '0;
            state <= IDLE;
          end else if (wait_cnt == TW'(TIMEOUT)) begin
            err   <= 1'b1;
            busy  <= '0;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - writeback stage driving the register file write port
module writeback_unit
  import mips_lite_pkg::*;
#(
  parameter int DATA_W  = REG_W,
  parameter int ADDR_W  = REG_IDX_W,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ex_valid,
  output logic                    ex_ready,
  input  logic [2:0]              ex_alu_op,
  input  logic [ADDR_W-1:0]       ex_rs,
  input  logic [ADDR_W-1:0]       ex_rd,
  input  logic [DATA_W-1:0]       ex_result,
  input  logic                    ex_reg_write,
  input  logic                    ex_is_load,
  input  logic                    mem_rvalid,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [2:0]              rf_alu_op,
  output logic [ADDR_W-1:0]       rf_rs,
  output logic [ADDR_W-1:0]       rf_rd,
  output logic [DATA_W-1:0]       rf_from_reg_src,
  output logic                    rf_reg_write,
  output logic [(1<<ADDR_W)-1:0]  busy,
  output logic                    err,
  output logic [CNT_W-1:0]        retire_count
);

  wb_state_t         state;
  logic              accept;
  logic              load_start;
  logic              alu_write;
  logic              load_done;
  logic              retire;
  logic [ADDR_W-1:0] dest;
  logic [2:0]        lat_alu_op;
  logic [ADDR_W-1:0] lat_rs;
  logic [ADDR_W-1:0] lat_rd;

  assign ex_ready   = (state == IDLE);
  assign accept     = ex_valid && ex_ready;
  // Same selection the register file applies: memory ops write rs, everything else rd
  assign dest       = (ex_alu_op != OP_MEM) ? ex_rd : ex_rs;
  assign load_start = accept && ex_is_load && ex_reg_write;
  assign alu_write  = accept && ex_reg_write && !ex_is_load;
  // A load retires when its data lands; anything else retires on acceptance
  assign retire     = (accept && !load_start) || load_done;

  load_tracker #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) u_load_tracker (
    .clk        (clk),
    .rst        (rst),
    .start      (load_start),
    .alu_op     (ex_alu_op),
    .rs         (ex_rs),
    .rd         (ex_rd),
    .dest       (dest),
    .mem_rvalid (mem_rvalid),
    .state      (state),
    .done       (load_done),
    .lat_alu_op (lat_alu_op),
    .lat_rs     (lat_rs),
    .lat_rd     (lat_rd),
    .busy       (busy),
    .err        (err)
  );

  // Register-file write port: one-cycle strobe, fields hold their last written value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_reg_write    <= 1'b0;
      rf_alu_op       <= '0;
      rf_rs           <= '0;
      rf_rd           <= '0;
      rf_from_reg_src <= '0;
    end else begin
      rf_reg_write <= 1'b0;
      if (alu_write) begin
        rf_reg_write    <= 1'b1;
        rf_alu_op       <= ex_alu_op;
        rf_rs           <= ex_rs;
        rf_rd           <= ex_rd;
        rf_from_reg_src <= ex_result;
      end else if (load_done) begin
        rf_reg_write    <= 1'b1;
        rf_alu_op       <= lat_alu_op;
        rf_rs           <= lat_rs;
        rf_rd           <= lat_rd;
        rf_from_reg_src <= mem_rdata;
      end
    end
  end

  // Retired-instruction counter, wraps naturally at its width
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_count <= '0;
    end else if (retire) begin
      retire_count <= retire_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - self-checking bench for writeback_unit
module tb_writeback_unit;

  localparam int TO = 15;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ex_valid, ex_ready;
  logic [2:0]    ex_alu_op, ex_rs, ex_rd;
  logic [7:0]    ex_result;
  logic          ex_reg_write, ex_is_load;
  logic          mem_rvalid;
  logic [7:0]    mem_rdata;
  logic [2:0]    rf_alu_op, rf_rs, rf_rd;
  logic [7:0]    rf_from_reg_src;
  logic          rf_reg_write;
  logic [7:0]    busy;
  logic          err;
  logic [CW-1:0] retire_count;

  int checks = 0;
  int errors = 0;

  writeback_unit #(.DATA_W(8), .ADDR_W(3), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .ex_ready        (ex_ready),
    .ex_alu_op       (ex_alu_op),
    .ex_rs           (ex_rs),
    .ex_rd           (ex_rd),
    .ex_result       (ex_result),
    .ex_reg_write    (ex_reg_write),
    .ex_is_load      (ex_is_load),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata),
    .rf_alu_op       (rf_alu_op),
    .rf_rs           (rf_rs),
    .rf_rd           (rf_rd),
    .rf_from_reg_src (rf_from_reg_src),
    .rf_reg_write    (rf_reg_write),
    .busy            (busy),
    .err             (err),
    .retire_count    (retire_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic          v;
    logic [2:0]    op;
    logic [2:0]    rs;
    logic [2:0]    rd;
    logic [7:0]    res;
    logic          rw;
    logic          ld;
    logic          rv;
    logic [7:0]    rdata;
    logic          e_we;
    logic [7:0]    e_data;
    logic [2:0]    e_op;
    logic [2:0]    e_rs;
    logic [2:0]    e_rd;
    logic [7:0]    e_busy;
    logic          e_ready;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vecs[11];

  // reference model state
  bit            m_pend;
  int            m_waited;
  logic [2:0]    m_op, m_rs, m_rd;
  logic [7:0]    m_busy;
  logic          m_err;
  logic [CW-1:0] m_cnt;
  logic          e_we;
  logic [7:0]    e_data;
  logic [2:0]    e_op, e_rs, e_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic we, input logic [7:0] data,
                           input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rd,
                           input logic [7:0] bsy, input logic er, input logic [CW-1:0] cnt,
                           input logic rdy);
    chk({tag, ".we"},    32'(rf_reg_write),    32'(we));
    chk({tag, ".data"},  32'(rf_from_reg_src), 32'(data));
    chk({tag, ".op"},    32'(rf_alu_op),       32'(op));
    chk({tag, ".rs"},    32'(rf_rs),           32'(rs));
    chk({tag, ".rd"},    32'(rf_rd),           32'(rd));
    chk({tag, ".busy"},  32'(busy),            32'(bsy));
    chk({tag, ".err"},   32'(err),             32'(er));
    chk({tag, ".cnt"},   32'(retire_count),    32'(cnt));
    chk({tag, ".ready"}, 32'(ex_ready),        32'(rdy));
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] rs,
                       input logic [2:0] rd, input logic [7:0] res, input logic rw,
                       input logic ld, input logic rv, input logic [7:0] rdata);
    ex_valid     = v;
    ex_alu_op    = op;
    ex_rs        = rs;
    ex_rd        = rd;
    ex_result    = res;
    ex_reg_write = rw;
    ex_is_load   = ld;
    mem_rvalid   = rv;
    mem_rdata    = rdata;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic model_reset();
    m_pend = 1'b0; m_waited = 0; m_op = '0; m_rs = '0; m_rd = '0;
    m_busy = '0; m_err = 1'b0; m_cnt = '0;
    e_we = 1'b0; e_data = '0; e_op = '0; e_rs = '0; e_rd = '0;
  endtask

  // One clock edge of the architectural behaviour, from the inputs currently driven
  task automatic model_edge();
    e_we = 1'b0;
    if (!m_pend) begin
      if (ex_valid) begin
        if (ex_is_load && ex_reg_write) begin
          m_pend = 1'b1;
          m_waited = 0;
          m_op = ex_alu_op; m_rs = ex_rs; m_rd = ex_rd;
          m_busy = 8'd1 << ((ex_alu_op == 3'b111) ? ex_rs : ex_rd);
        end else begin
          m_cnt = m_cnt + CW'(1);
          if (ex_reg_write) begin
            e_we = 1'b1; e_data = ex_result; e_op = ex_alu_op; e_rs = ex_rs; e_rd = ex_rd;
          end
        end
      end
    end else begin
      m_waited++;
      if (mem_rvalid) begin
        e_we = 1'b1; e_data = mem_rdata; e_op = m_op; e_rs = m_rs; e_rd = m_rd;
        m_busy = '0; m_pend = 1'b0; m_cnt = m_cnt + CW'(1);
      end else if (m_waited == TO + 1) begin
        m_err = 1'b1; m_busy = '0; m_pend = 1'b0;
      end
    end
  endtask

  initial begin
    vecs[0]  = '{1, 0, 0, 5, 8'h3C, 1, 0, 0, 8'h00, 1, 8'h3C, 0, 0, 5, 8'h00, 1, 1};
    vecs[1]  = '{1, 7, 2, 6, 8'h00, 1, 1, 0, 8'h00, 0, 8'h3C, 0, 0, 5, 8'h04, 0, 1};
    vecs[2]  = '{1, 0, 3, 3, 8'h77, 1, 0, 0, 8'h00, 0, 8'h3C, 0, 0, 5, 8'h04, 0, 1};
    vecs[3]  = '{0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h3C, 0, 0, 5, 8'h04, 0, 1};
    vecs[4]  = '{0, 0, 0, 0, 8'h00, 0, 0, 1, 8'hA5, 1, 8'hA5, 7, 2, 6, 8'h00, 1, 2};
    vecs[5]  = '{1, 2, 1, 2, 8'h11, 0, 0, 0, 8'h00, 0, 8'hA5, 7, 2, 6, 8'h00, 1, 3};
    vecs[6]  = '{1, 1, 7, 1, 8'h5A, 1, 0, 0, 8'h00, 1, 8'h5A, 1, 7, 1, 8'h00, 1, 4};
    vecs[7]  = '{1, 7, 3, 4, 8'h00, 0, 1, 0, 8'h00, 0, 8'h5A, 1, 7, 1, 8'h00, 1, 5};
    vecs[8]  = '{0, 0, 0, 0, 8'h00, 0, 0, 1, 8'hEE, 0, 8'h5A, 1, 7, 1, 8'h00, 1, 5};
    vecs[9]  = '{1, 0, 1, 0, 8'h00, 1, 1, 0, 8'h00, 0, 8'h5A, 1, 7, 1, 8'h01, 0, 5};
    vecs[10] = '{0, 0, 0, 0, 8'h00, 0, 0, 1, 8'h0F, 1, 8'h0F, 0, 1, 0, 8'h00, 1, 6};

    // reset state
    idle();
    rst = 1'b0;
    step();
    step();
    check_out("reset", 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1);
    rst = 1'b1;

    // directed vector table
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].v, vecs[i].op, vecs[i].rs, vecs[i].rd, vecs[i].res,
            vecs[i].rw, vecs[i].ld, vecs[i].rv, vecs[i].rdata);
      step();
      check_out($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_data, vecs[i].e_op,
                vecs[i].e_rs, vecs[i].e_rd, vecs[i].e_busy, 1'b0, vecs[i].e_cnt,
                vecs[i].e_ready);
    end

    // load timeout, then a late rvalid that must be ignored
    do_reset();
    drive(1'b1, 3'd7, 3'd4, 3'd1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
    step();
    chk("to.busy0", 32'(busy), 32'h10);
    chk("to.ready0", 32'(ex_ready), 32'd0);
    idle();
    for (int k = 1; k <= TO + 1; k++) begin
      step();
      chk($sformatf("to.we%0d", k), 32'(rf_reg_write), 32'd0);
      if (k <= TO) begin
        chk($sformatf("to.busy%0d", k), 32'(busy), 32'h10);
        chk($sformatf("to.err%0d", k), 32'(err), 32'd0);
      end else begin
        chk("to.err", 32'(err), 32'd1);
        chk("to.busy", 32'(busy), 32'd0);
        chk("to.ready", 32'(ex_ready), 32'd1);
      end
    end
    drive(1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h33);
    step();
    check_out("to.late", 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 1);

    // rvalid arriving on the exact timeout cycle wins
    do_reset();
    drive(1'b1, 3'd7, 3'd3, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
    step();
    idle();
    repeat (TO) step();
    chk("edge.busy", 32'(busy), 32'h08);
    drive(1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h99);
    step();
    check_out("edge", 1, 8'h99, 7, 3, 0, 8'h00, 0, 1, 1);
    idle();

    // async reset in the middle of LOAD_WAIT
    do_reset();
    drive(1'b1, 3'd3, 3'd2, 3'd4, 8'hC3, 1'b1, 1'b0, 1'b0, 8'h00);
    step();
    drive(1'b1, 3'd7, 3'd5, 3'd6, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
    step();
    idle();
    step();
    chk("ar.pre_busy", 32'(busy), 32'h20);
    chk("ar.pre_data", 32'(rf_from_reg_src), 32'hC3);
    #2;
    rst = 1'b0;
    #1;
    check_out("ar.now", 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1);
    step();
    rst = 1'b1;
    drive(1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF);
    step();
    check_out("ar.after", 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1);

    // randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)));
      step();
      model_edge();
      check_out($sformatf("rand%0d", n), e_we, e_data, e_op, e_rs, e_rd,
                m_busy, m_err, m_cnt, !m_pend);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
